// File: rtl/serial_sub.sv
// Bit-serial full subtractor: D = A - B - Bin, one bit per clock, LSB first, start/done handshake.
// Define SERIAL_SUB_OVF_EN to add the registered two's-complement overflow output ovf.
module serial_sub #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Bin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] D,
  output logic         Bo
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [W-1:0]  res;
  logic          br;
  logic [CW-1:0] cnt;

  logic          d_bit;
  logic          br_nxt;
  logic [W-1:0]  res_nxt;

  function automatic logic [1:0] fsub(input logic a, input logic b, input logic bi);
    fsub[0] = a ^ b ^ bi;
    fsub[1] = (~a & b) | (~(a ^ b) & bi);
  endfunction

  always_comb begin
    {br_nxt, d_bit} = fsub(a_sh[0], b_sh[0], br);
    // Difference bits enter at the MSB so the LSB lands at bit 0 after W steps.
    res_nxt = (res >> 1) | (W'(d_bit) << (W - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      D     <= '0;
      Bo    <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      br    <= 1'b0;
      cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sh  <= A;
            b_sh  <= B;
            br    <= Bin;
            res   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          res  <= res_nxt;
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= br_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            D     <= res_nxt;
            Bo    <= br_nxt;
`ifdef SERIAL_SUB_OVF_EN
            // br here is the borrow into the MSB; overflow when it differs from the borrow out.
            ovf   <= br ^ br_nxt;
`endif
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Bench for serial_sub: W=1 exhaustive table, W=8 directed table, handshake/reset sequences, random vs model.
module tb_serial_sub;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       bin8 = 1'b0;
  logic       busy8, done8, bo8;
  logic [7:0] d8;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       bin1 = 1'b0;
  logic       busy1, done1, bo1;
  logic [0:0] d1;

`ifdef SERIAL_SUB_OVF_EN
  logic       ovf8, ovf1;
`endif

  int nvec = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  serial_sub #(.W(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8), .Bin(bin8),
    .busy(busy8), .done(done8), .D(d8), .Bo(bo8)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_sub #(.W(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1), .Bin(bin1),
    .busy(busy1), .done(done1), .D(d1), .Bo(bo1)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf1)
`endif
  );

  typedef struct {
    logic [7:0] a, b;
    logic       bi;
    logic [7:0] d;
    logic       bo, ov;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                     output logic [7:0] d, output logic bo, output logic ov,
                     output int lat, output int bcnt);
    @(negedge clk);
    a8 = a; b8 = b; bin8 = bi; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    lat = 0; bcnt = 0;
    while (!done8 && lat < 40) begin
      if (busy8) bcnt++;
      @(negedge clk);
      lat++;
    end
    d = d8; bo = bo8;
`ifdef SERIAL_SUB_OVF_EN
    ov = ovf8;
`else
    ov = 1'b0;
`endif
  endtask

  task automatic op1(input logic a, input logic b, input logic bi,
                     output logic d, output logic bo, output int lat);
    @(negedge clk);
    a1 = a; b1 = b; bin1 = bi; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    a1 = ~a1; b1 = ~b1; bin1 = ~bin1;
    lat = 0;
    while (!done1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    d = d1; bo = bo1;
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b, input logic bi);
    int u, s;
    logic [7:0] d;
    logic bo, ov;
    u  = int'(a) - int'(b) - int'(bi);
    s  = int'($signed(a)) - int'($signed(b)) - int'(bi);
    d  = 8'(u & 255);
    bo = (u < 0);
    ov = (s > 127) || (s < -128);
    return {ov, bo, d};
  endfunction

  initial begin
    vec_t t8[4];
    logic [1:0] t1[8];
    logic [7:0] d;
    logic bo, ov, dd;
    int lat, bcnt, seen;
    logic [9:0] m;

    t8[0] = '{a: 8'h05, b: 8'h03, bi: 1'b0, d: 8'h02, bo: 1'b0, ov: 1'b0};
    t8[1] = '{a: 8'h00, b: 8'h01, bi: 1'b0, d: 8'hFF, bo: 1'b1, ov: 1'b0};
    t8[2] = '{a: 8'h80, b: 8'h01, bi: 1'b0, d: 8'h7F, bo: 1'b0, ov: 1'b1};
    t8[3] = '{a: 8'h7F, b: 8'hFF, bi: 1'b1, d: 8'h7F, bo: 1'b1, ov: 1'b0};
    // {Bo, D} for (A,B,Bin) = 000 .. 111
    t1[0] = 2'b00; t1[1] = 2'b11; t1[2] = 2'b11; t1[3] = 2'b10;
    t1[4] = 2'b01; t1[5] = 2'b00; t1[6] = 2'b00; t1[7] = 2'b11;

    // Reset state
    #12;
    chk("rst busy", busy8, 0);
    chk("rst done", done8, 0);
    chk("rst D", d8, 0);
    chk("rst Bo", bo8, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // W=1 exhaustive
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      op1(v[2], v[1], v[0], dd, bo, lat);
      chk($sformatf("w1 D %0d", i), dd, t1[i][0]);
      chk($sformatf("w1 Bo %0d", i), bo, t1[i][1]);
      chk($sformatf("w1 lat %0d", i), lat, 1);
    end

    // W=8 directed table
    for (int i = 0; i < 4; i++) begin
      op8(t8[i].a, t8[i].b, t8[i].bi, d, bo, ov, lat, bcnt);
      chk($sformatf("w8 D %0d", i), d, t8[i].d);
      chk($sformatf("w8 Bo %0d", i), bo, t8[i].bo);
`ifdef SERIAL_SUB_OVF_EN
      chk($sformatf("w8 ovf %0d", i), ov, t8[i].ov);
`endif
      chk($sformatf("w8 lat %0d", i), lat, 8);
      chk($sformatf("w8 busy cycles %0d", i), bcnt, 8);
      chk($sformatf("w8 busy at done %0d", i), busy8, 0);
    end
    @(negedge clk);
    chk("done one cycle", done8, 0);
    chk("D held", d8, 8'h7F);

    // start during RUN is ignored and not queued
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55; bin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 4;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("ignore lat", lat, 8);
    chk("ignore D", d8, 8'h0F);
    chk("ignore Bo", bo8, 0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy8 || done8) seen++;
    end
    chk("ignore not queued", seen, 0);

    // Back-to-back with start held through DONE
    @(negedge clk);
    a8 = 8'h20; b8 = 8'h05; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    a8 = 8'h40; b8 = 8'h11; bin8 = 1'b1;
    lat = 0;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b first lat", lat, 8);
    chk("b2b first D", d8, 8'h1B);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk("b2b no idle", busy8, 1);
    end while (!done8 && lat < 40);
    start8 = 1'b0;
    chk("b2b second lat", lat, 9);
    chk("b2b second D", d8, 8'h2E);
    chk("b2b second Bo", bo8, 0);

    // Reset mid-RUN
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst busy", busy8, 0);
    chk("midrst done", done8, 0);
    chk("midrst D", d8, 0);
    chk("midrst Bo", bo8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) seen++;
    end
    chk("midrst no done", seen, 0);

    // Random operands against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      logic rbi;
      ra = 8'($urandom); rb = 8'($urandom); rbi = 1'($urandom);
      if (i == 0) begin ra = 8'h00; rb = 8'hFF; rbi = 1'b1; end
      m = model8(ra, rb, rbi);
      op8(ra, rb, rbi, d, bo, ov, lat, bcnt);
      chk($sformatf("rnd D %0h-%0h-%0d", ra, rb, rbi), d, m[7:0]);
      chk($sformatf("rnd Bo %0h-%0h-%0d", ra, rb, rbi), bo, m[8]);
`ifdef SERIAL_SUB_OVF_EN
      chk($sformatf("rnd ovf %0h-%0h-%0d", ra, rb, rbi), ov, m[9]);
`endif
      chk($sformatf("rnd lat %0d", i), lat, 8);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
